// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce
// and a one-cycle strobe per accepted key.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    col_idx, col_idx_nx;
  logic [DW-1:0] dwell, dwell_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    sync1, rows_s;
  logic [3:0]    pat, pat_nx;
  logic [1:0]    row_lat, row_lat_nx;
  logic [1:0]    row_sel;
  logic [3:0]    code_nx;
  logic          valid_nx, held_nx;
  logic [3:0]    low;
  logic          one_low;

  function automatic logic [3:0] enc(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: enc = 4'h1;
      4'h1: enc = 4'h2;
      4'h2: enc = 4'h3;
      4'h3: enc = 4'hA;
      4'h4: enc = 4'h4;
      4'h5: enc = 4'h5;
      4'h6: enc = 4'h6;
      4'h7: enc = 4'hB;
      4'h8: enc = 4'h7;
      4'h9: enc = 4'h8;
      4'hA: enc = 4'h9;
      4'hB: enc = 4'hC;
      4'hC: enc = 4'hE;
      4'hD: enc = 4'h0;
      4'hE: enc = 4'hF;
      4'hF: enc = 4'hD;
    endcase
  endfunction

  assign col_n = ~(4'b0001 << col_idx);

  // exactly one row pulled low counts as a key; none or several do not
  assign low     = ~rows_s;
  assign one_low = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);

  always_comb begin
    case (rows_s)
      4'b1110: row_sel = 2'd0;
      4'b1101: row_sel = 2'd1;
      4'b1011: row_sel = 2'd2;
      4'b0111: row_sel = 2'd3;
      default: row_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      sync1  <= row_n;
      rows_s <= sync1;
    end
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    dwell_nx   = dwell;
    cnt_nx     = cnt;
    pat_nx     = pat;
    row_lat_nx = row_lat;
    code_nx    = key_code;
    valid_nx   = 1'b0;
    held_nx    = key_held;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (one_low) begin
            pat_nx     = rows_s;
            row_lat_nx = row_sel;
            cnt_nx     = '0;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s == pat) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = HELD;
            valid_nx = 1'b1;
            held_nx  = 1'b1;
            code_nx  = enc(row_lat, col_idx);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else begin
          cnt_nx   = '0;
          dwell_nx = '0;
          state_nx = SCAN;
        end
      end
      HELD: begin
        if (rows_s == 4'hF) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (rows_s != 4'hF) begin
          cnt_nx   = '0;
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nx     = '0;
          dwell_nx   = '0;
          col_idx_nx = col_idx + 2'd1;
          held_nx    = 1'b0;
          state_nx   = SCAN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      dwell     <= '0;
      cnt       <= '0;
      pat       <= 4'hF;
      row_lat   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      dwell     <= dwell_nx;
      cnt       <= cnt_nx;
      pat       <= pat_nx;
      row_lat   <= row_lat_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

endmodule
